// File: rtl/multi_cycle_cpu_if.sv
// Shared instruction/data memory port of the multi-cycle core.
// A transfer completes in the cycle where mem_req and mem_ready are both high.
interface multi_cycle_cpu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM over one
// shared memory port, with illegal/misaligned trapping and cycle/retire counters.
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_cycle_cpu_if.master    bus,
  output logic                 retire,
  output logic                 trap,
  output logic [31:0]          pc,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt,
  output logic signed [31:0]   r [0:31]
);
  localparam int         RW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
  logic [31:0] r_regs [0:NREGS-1];
  logic [CNT_W-1:0] r_cycle, r_instret;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_reg_bad;
  logic [31:0] w_imm, w_alu_res, w_pc4, w_pc_next, w_rf_wdata, w_addr;
  logic        w_taken, w_req, w_we, w_retire, w_rf_we, w_pc_we;
  logic        w_ir_we, w_ab_we, w_alu_we, w_mdr_we;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_pc4    = r_pc + 32'd4;

  // Legality and which register fields the format actually uses.
  always_comb begin
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_legal   = ((w_f7 == 7'h00) && (w_f3 == 3'd0 || w_f3 == 3'd7 || w_f3 == 3'd6 || w_f3 == 3'd2))
                 || ((w_f7 == 7'h20) && (w_f3 == 3'd0));
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_IMM:    begin w_legal = (w_f3 == 3'd0); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_LOAD:   begin w_legal = (w_f3 == 3'd2); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_STORE:  begin w_legal = (w_f3 == 3'd2); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_BRANCH: begin w_legal = (w_f3 == 3'd0 || w_f3 == 3'd4); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_JAL:    begin w_legal = 1'b1; w_use_rd = 1'b1; end
      OP_JALR:   begin w_legal = (w_f3 == 3'd0); w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      default: ;
    endcase
  end

  assign w_reg_bad = (w_use_rd  && ({1'b0, w_rd}  >= NREGS_L))
                  || (w_use_rs1 && ({1'b0, w_rs1} >= NREGS_L))
                  || (w_use_rs2 && ({1'b0, w_rs2} >= NREGS_L));

  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    case (w_opcode)
      OP_STORE:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      OP_BRANCH: w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      OP_JAL:    w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      default: ;
    endcase
  end

  always_comb begin
    w_alu_res = r_a + r_imm;
    if (w_opcode == OP_R) begin
      case (w_f3)
        3'd0:    w_alu_res = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
        3'd7:    w_alu_res = r_a & r_b;
        3'd6:    w_alu_res = r_a | r_b;
        3'd2:    w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
        default: w_alu_res = r_a + r_b;
      endcase
    end
  end

  assign w_taken = (w_f3 == 3'd0) ? (r_a == r_b) : ($signed(r_a) < $signed(r_b));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req = 1'b0;  w_we = 1'b0;  w_addr = r_pc;
    w_retire = 1'b0;  w_rf_we = 1'b0;  w_rf_wdata = r_alu;
    w_pc_we = 1'b0;  w_pc_next = w_pc4;
    w_ir_we = 1'b0;  w_ab_we = 1'b0;  w_alu_we = 1'b0;  w_mdr_we = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_pc[1:0] != 2'b00) begin
          w_state_next = S_TRAP;
        end else begin
          w_req = 1'b1;
          if (bus.mem_ready) begin
            w_ir_we      = 1'b1;
            w_state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        w_ab_we      = 1'b1;
        w_state_next = (!w_legal || w_reg_bad) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        w_alu_we = 1'b1;
        if (w_opcode == OP_BRANCH) begin
          w_pc_we      = 1'b1;
          w_pc_next    = w_taken ? (r_pc + r_imm) : w_pc4;
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_opcode == OP_LOAD || w_opcode == OP_STORE) begin
          w_state_next = (w_alu_res[1:0] != 2'b00) ? S_TRAP : S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_we   = (w_opcode == OP_STORE);
        w_addr = r_alu;
        if (bus.mem_ready) begin
          if (w_opcode == OP_STORE) begin
            w_pc_we      = 1'b1;
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_mdr_we     = 1'b1;
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_retire = 1'b1;
        w_pc_we  = 1'b1;
        if (w_opcode == OP_LOAD) begin
          w_rf_wdata = r_mdr;
        end else if (w_opcode == OP_JAL) begin
          w_rf_wdata = w_pc4;
          w_pc_next  = r_pc + r_imm;
        end else if (w_opcode == OP_JALR) begin
          // A was latched in DECODE, so rd==rs1 cannot corrupt the target.
          w_rf_wdata = w_pc4;
          w_pc_next  = (r_a + r_imm) & ~32'd1;
        end
        w_state_next = S_FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (w_ir_we)  r_ir  <= bus.mem_rdata;
      if (w_ab_we) begin
        r_a   <= r_regs[w_rs1[RW-1:0]];
        r_b   <= r_regs[w_rs2[RW-1:0]];
        r_imm <= w_imm;
      end
      if (w_alu_we) r_alu <= w_alu_res;
      if (w_mdr_we) r_mdr <= bus.mem_rdata;
      if (w_pc_we)  r_pc  <= w_pc_next;
      if (r_state != S_TRAP) r_cycle <= r_cycle + CNT_W'(1);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Entry 0 is never written, so x0 always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_rf_we && (w_rd != 5'd0)) begin
      r_regs[w_rd[RW-1:0]] <= w_rf_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rview
      if (gi < NREGS) begin : g_live
        assign r[gi] = r_regs[gi];
      end else begin : g_zero
        assign r[gi] = '0;
      end
    end
  endgenerate

  assign bus.mem_req   = w_req & ~rst;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = r_b;
  assign retire        = w_retire & ~rst;
  assign trap          = (r_state == S_TRAP);
  assign pc            = r_pc;
  assign cycle_cnt     = r_cycle;
  assign instret_cnt   = r_instret;
endmodule
